// File: rtl/gumnut_pkg.sv
// Shared types and constants for the Gumnut core's return/interrupt context store.
package gumnut_pkg;

    localparam int PC_W              = 12;
    localparam int RET_DEPTH_DEFAULT = 8;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic {
        INT_IDLE,
        INT_ACTIVE
    } int_state_e;

endpackage

// File: rtl/int_ctx_reg.sv
// Interrupt context register: two-state FSM holding the PC and carry/zero flags
// captured at interrupt entry. No nesting; saved values are held after reti.
module int_ctx_reg
    import gumnut_pkg::*;
#(
    parameter int AW = PC_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          int_save_i,
    input  logic          int_restore_i,
    input  logic [AW-1:0] PC_i,
    input  logic          carry_i,
    input  logic          zero_i,
    output logic [AW-1:0] intPC_o,
    output logic          intcarry_o,
    output logic          intzero_o,
    output logic          int_active_o
);

    int_state_e    r_state;
    int_state_e    w_state_nxt;
    logic          w_capture;
    logic [AW-1:0] r_pc;
    logic          r_carry;
    logic          r_zero;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= INT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and capture strobe: save wins in IDLE, restore wins in ACTIVE
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            INT_IDLE: begin
                if (int_save_i) begin
                    w_state_nxt = INT_ACTIVE;
                    w_capture   = 1'b1;
                end
            end
            INT_ACTIVE: begin
                if (int_restore_i) begin
                    w_state_nxt = INT_IDLE;
                end
            end
            default: w_state_nxt = INT_IDLE;
        endcase
    end

    // Saved context, loaded only on entry from IDLE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc    <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_capture) begin
            r_pc    <= PC_i;
            r_carry <= carry_i;
            r_zero  <= zero_i;
        end
    end

    assign intPC_o      = r_pc;
    assign intcarry_o   = r_carry;
    assign intzero_o    = r_zero;
    assign int_active_o = (r_state == INT_ACTIVE);

endmodule

// File: rtl/ret_stack.sv
// Return-address stack and interrupt context store for the Gumnut core.
// Optional macro RET_STACK_WRAP_EN: when defined, a push while full overwrites
// the oldest entry (circular stack) instead of being discarded.
module ret_stack
    import gumnut_pkg::*;
#(
    parameter int DEPTH = RET_DEPTH_DEFAULT,
    parameter int AW    = PC_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] retaddr_i,
    output logic [AW-1:0] stackaddr_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overflow_o,
    output logic          underflow_o,
    input  logic          clr_err_i,
    input  logic          int_save_i,
    input  logic          int_restore_i,
    input  logic [AW-1:0] PC_i,
    input  logic          carry_i,
    input  logic          zero_i,
    output logic [AW-1:0] intPC_o,
    output logic          intcarry_o,
    output logic          intzero_o,
    output logic          int_active_o
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    // Entries are addressed through a modulo write pointer rather than sp so the
    // circular variant needs no shifting; without wrap r_wp always equals sp mod DEPTH.
    logic [AW-1:0]  r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [IW-1:0]  r_wp;
    logic           r_ovf;
    logic           r_unf;

    logic [IW-1:0]  w_top_idx;
    logic           w_empty;
    logic           w_full;
    logic           w_replace;
    logic           w_push;
    logic           w_push_ok;
    logic           w_wrap;
    logic           w_pop_ok;
    logic           w_ovf_evt;
    logic           w_unf_evt;

    assign w_top_idx = r_wp - IW'(1);
    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SPW'(DEPTH));

    assign w_replace = push_i & pop_i & ~w_empty;
    assign w_push    = push_i & (~pop_i | w_empty);
    assign w_push_ok = w_push & ~w_full;
    assign w_pop_ok  = pop_i & ~push_i & ~w_empty;
    assign w_ovf_evt = w_push & w_full;
    assign w_unf_evt = pop_i & w_empty;

`ifdef RET_STACK_WRAP_EN
    assign w_wrap = w_push & w_full;
`else
    assign w_wrap = 1'b0;
`endif

    // Entry array writes: replace top on push+pop, else write at the pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_replace) begin
            r_mem[w_top_idx] <= retaddr_i;
        end else if (w_push_ok || w_wrap) begin
            r_mem[r_wp] <= retaddr_i;
        end
    end

    // Occupancy counter and write pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sp <= '0;
            r_wp <= '0;
        end else if (w_push_ok) begin
            r_sp <= r_sp + SPW'(1);
            r_wp <= r_wp + IW'(1);
        end else if (w_wrap) begin
            r_wp <= r_wp + IW'(1);
        end else if (w_pop_ok) begin
            r_sp <= r_sp - SPW'(1);
            r_wp <= r_wp - IW'(1);
        end
    end

    // Sticky error flags; a new error event beats a same-cycle clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_evt)      r_ovf <= 1'b1;
            else if (clr_err_i) r_ovf <= 1'b0;
            if (w_unf_evt)      r_unf <= 1'b1;
            else if (clr_err_i) r_unf <= 1'b0;
        end
    end

    assign stackaddr_o = w_empty ? '0 : r_mem[w_top_idx];
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;

    int_ctx_reg #(
        .AW(AW)
    ) u_int_ctx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .int_save_i   (int_save_i),
        .int_restore_i(int_restore_i),
        .PC_i         (PC_i),
        .carry_i      (carry_i),
        .zero_i       (zero_i),
        .intPC_o      (intPC_o),
        .intcarry_o   (intcarry_o),
        .intzero_o    (intzero_o),
        .int_active_o (int_active_o)
    );

endmodule

// File: tb/tb_ret_stack.sv
// Testbench for ret_stack: directed scenarios plus randomized traffic compared
// against a queue-based reference model. Honors RET_STACK_WRAP_EN.
module tb_ret_stack;
    import gumnut_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 12;

    logic          clk;
    logic          rst;
    logic          push, pop, clr_err;
    logic [AW-1:0] retaddr;
    logic [AW-1:0] stackaddr;
    logic          empty, full, ovf, unf;
    logic          int_save, int_restore;
    logic [AW-1:0] pc;
    logic          carry, zero;
    logic [AW-1:0] int_pc;
    logic          int_carry, int_zero, int_active;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model state
    pc_t  m_q[$];
    logic m_ovf, m_unf;
    logic m_act, m_carry, m_zero;
    pc_t  m_pc;

    ret_stack #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (push),
        .pop_i        (pop),
        .retaddr_i    (retaddr),
        .stackaddr_o  (stackaddr),
        .empty_o      (empty),
        .full_o       (full),
        .overflow_o   (ovf),
        .underflow_o  (unf),
        .clr_err_i    (clr_err),
        .int_save_i   (int_save),
        .int_restore_i(int_restore),
        .PC_i         (pc),
        .carry_i      (carry),
        .zero_i       (zero),
        .intPC_o      (int_pc),
        .intcarry_o   (int_carry),
        .intzero_o    (int_zero),
        .int_active_o (int_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pc_t model_top();
        return (m_q.size() == 0) ? pc_t'(0) : m_q[m_q.size()-1];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        m_act = 1'b0; m_carry = 1'b0; m_zero = 1'b0; m_pc = '0;
    endtask

    task automatic model_step();
        bit was_empty, was_full, ovf_ev, unf_ev;
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        ovf_ev = push && !pop && was_full;
        unf_ev = pop && was_empty;
        if (push && pop && !was_empty) begin
            m_q[m_q.size()-1] = retaddr;
        end else if (push) begin
            if (!was_full) m_q.push_back(retaddr);
`ifdef RET_STACK_WRAP_EN
            else begin
                void'(m_q.pop_front());
                m_q.push_back(retaddr);
            end
`endif
        end else if (pop && !was_empty) begin
            void'(m_q.pop_back());
        end
        if (ovf_ev) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
        if (unf_ev) m_unf = 1'b1; else if (clr_err) m_unf = 1'b0;
        if (m_act) begin
            if (int_restore) m_act = 1'b0;
        end else if (int_save) begin
            m_act = 1'b1; m_pc = pc; m_carry = carry; m_zero = zero;
        end
    endtask

    task automatic compare_all();
        check("stackaddr", 32'(stackaddr), 32'(model_top()));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("overflow", 32'(ovf), 32'(m_ovf));
        check("underflow", 32'(unf), 32'(m_unf));
        check("intPC", 32'(int_pc), 32'(m_pc));
        check("intcarry", 32'(int_carry), 32'(m_carry));
        check("intzero", 32'(int_zero), 32'(m_zero));
        check("int_active", 32'(int_active), 32'(m_act));
    endtask

    task automatic idle_inputs();
        push = 0; pop = 0; clr_err = 0; retaddr = '0;
        int_save = 0; int_restore = 0; pc = '0; carry = 0; zero = 0;
    endtask

    // drive one cycle of inputs, clock it, update the model, compare
    task automatic step(input logic p, input logic po, input logic [AW-1:0] a,
                        input logic c, input logic s, input logic r,
                        input logic [AW-1:0] ipc, input logic cy, input logic zr);
        push = p; pop = po; retaddr = a; clr_err = c;
        int_save = s; int_restore = r; pc = ipc; carry = cy; zero = zr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic stk(input logic p, input logic po, input logic [AW-1:0] a, input logic c);
        step(p, po, a, c, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        #2;
        compare_all();
        @(posedge clk); #1;
        rst = 1'b0;

        // basic push / pop
        stk(1, 0, 12'h010, 0);
        stk(1, 0, 12'h020, 0);
        stk(1, 0, 12'h030, 0);
        check("top_after_3_push", 32'(stackaddr), 32'h030);
        stk(0, 1, '0, 0);
        check("pop1", 32'(stackaddr), 32'h020);
        stk(0, 1, '0, 0);
        check("pop2", 32'(stackaddr), 32'h010);
        stk(0, 1, '0, 0);
        check("pop3", 32'(stackaddr), 32'h000);
        check("empty_after_pops", 32'(empty), 32'h1);

        // underflow and clear precedence
        stk(0, 1, '0, 0);
        check("underflow_set", 32'(unf), 32'h1);
        stk(0, 0, '0, 1);
        check("underflow_clr", 32'(unf), 32'h0);
        stk(0, 1, '0, 1);
        check("underflow_set_beats_clr", 32'(unf), 32'h1);
        stk(1, 1, 12'h0AA, 1);
        check("pushpop_empty_unf", 32'(unf), 32'h1);
        stk(0, 1, '0, 0);
        stk(0, 0, '0, 1);

        // fill past full
        for (int i = 1; i <= DEPTH + 1; i++) stk(1, 0, AW'(12'h100 + i), 0);
        check("full_after_9", 32'(full), 32'h1);
        check("overflow_after_9", 32'(ovf), 32'h1);
`ifdef RET_STACK_WRAP_EN
        check("top_after_9", 32'(stackaddr), 32'h109);
`else
        check("top_after_9", 32'(stackaddr), 32'h108);
`endif
        stk(1, 1, 12'h1FF, 1);
        check("replace_full_no_ovf_clr", 32'(ovf), 32'h0);
        for (int i = 0; i < DEPTH; i++) stk(0, 1, '0, 0);
        check("empty_after_drain", 32'(empty), 32'h1);

        // replace with push+pop together
        stk(1, 0, 12'h100, 0);
        stk(1, 1, 12'h200, 0);
        check("replace_top", 32'(stackaddr), 32'h200);
        stk(0, 1, '0, 0);
        check("replace_sp_was_1", 32'(empty), 32'h1);

        // interrupt context
        step(0, 0, '0, 0, 1, 0, 12'hABC, 1, 0);
        check("int_save_pc", 32'(int_pc), 32'hABC);
        check("int_save_act", 32'(int_active), 32'h1);
        step(0, 0, '0, 0, 1, 0, 12'h123, 0, 1);
        check("int_nested_hold", 32'(int_pc), 32'hABC);
        step(0, 0, '0, 0, 1, 1, 12'h456, 0, 1);
        check("int_restore_act", 32'(int_active), 32'h0);
        check("int_restore_hold", 32'(int_pc), 32'hABC);
        step(0, 0, '0, 0, 1, 1, 12'h789, 0, 1);
        check("int_save_wins_idle", 32'(int_pc), 32'h789);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned k;
            logic p, po, c, s, r;
            k  = $urandom_range(0, 99);
            p  = (k < 45) || (k >= 90);
            po = (k >= 45);
            c  = ($urandom_range(0, 19) == 0);
            s  = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 9) == 0);
            step(p, po, AW'($urandom), c, s, r, AW'($urandom), 1'($urandom), 1'($urandom));
        end

        // async reset mid-operation with sp = 3 and ACTIVE
        idle_inputs();
        do_reset();
        stk(1, 0, 12'h111, 0);
        stk(1, 0, 12'h222, 0);
        stk(1, 0, 12'h333, 0);
        step(0, 1, '0, 0, 1, 0, 12'hDEF, 1, 1);
        stk(1, 0, 12'h444, 0);
        push = 1'b1; retaddr = 12'h555;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst_empty", 32'(empty), 32'h1);
        check("async_rst_active", 32'(int_active), 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ret_stack.md
Name: ret_stack

Overview:
- Return-address and interrupt-context store for the Gumnut core.
- It is the producer of the two saved-PC values the next-PC selector reads:
  - stackaddr_o: top of the subroutine return stack, used on `ret`.
  - intPC_o: PC captured at interrupt entry, used on `reti`.
- Pushed by the control unit on `jsb`, popped on `ret`.
- Captures PC and the carry/zero flags on interrupt acceptance and releases them on `reti`.

Parameters:
- DEPTH, 8, number of return-address entries; power of two, minimum 2.
- AW, 12, PC/address width in bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- push_i  input  1  `jsb` executing: push retaddr_i.
- pop_i  input  1  `ret` executing: pop the top entry.
- retaddr_i  input  AW  return address to push (current PC+1).
- stackaddr_o  output  AW  current top-of-stack entry; 0 when empty.
- empty_o  output  1  no entries held.
- full_o  output  1  DEPTH entries held.
- overflow_o  output  1  sticky: a push was attempted while full.
- underflow_o  output  1  sticky: a pop was attempted while empty.
- clr_err_i  input  1  clears overflow_o and underflow_o.
- int_save_i  input  1  interrupt accepted: capture context.
- int_restore_i  input  1  `reti` executing: release context.
- PC_i  input  AW  PC to save on interrupt entry.
- carry_i  input  1  carry flag to save.
- zero_i  input  1  zero flag to save.
- intPC_o  output  AW  saved interrupt PC.
- intcarry_o  output  1  saved carry flag.
- intzero_o  output  1  saved zero flag.
- int_active_o  output  1  inside an interrupt handler.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - sp = 0; all entries cleared.
  - stackaddr_o = 0, empty_o = 1, full_o = 0, overflow_o = 0, underflow_o = 0.
  - intPC_o = 0, intcarry_o = 0, intzero_o = 0, int_active_o = 0.
- Stack state:
  - Entry array plus an occupancy counter sp, range 0..DEPTH, width $clog2(DEPTH)+1.
  - stackaddr_o = entry[sp-1], driven combinationally from registered state; it changes the cycle after the push or pop edge.
  - empty_o = (sp == 0); full_o = (sp == DEPTH).
- push_i only:
  - Not full: entry[sp] <= retaddr_i; sp <= sp+1.
  - Full: push discarded, contents unchanged, overflow_o <= 1.
- pop_i only:
  - Not empty: sp <= sp-1. The vacated entry need not be cleared, but stackaddr_o must read 0 when sp == 0.
  - Empty: no change, underflow_o <= 1.
- push_i and pop_i in the same cycle:
  - Non-empty: top entry replaced by retaddr_i, sp unchanged, no error flags.
  - Empty: performs the push only, and sets underflow_o.
- Error flags:
  - clr_err_i clears both sticky flags.
  - If an error event and clr_err_i occur in the same cycle, the set wins.
- Interrupt context, two-state FSM:
  - IDLE -> ACTIVE on int_save_i. Capture PC_i, carry_i and zero_i into intPC_o, intcarry_o and intzero_o; int_active_o <= 1.
  - int_save_i while ACTIVE is ignored (no nesting); the captured values are held.
  - ACTIVE -> IDLE on int_restore_i; int_active_o <= 0. Saved values are held, so they remain valid during the restore cycle and afterwards.
  - int_restore_i while IDLE has no effect.
  - int_save_i and int_restore_i together in ACTIVE: the restore wins and the FSM goes to IDLE.
  - int_save_i and int_restore_i together in IDLE: the save wins.
- Independence: stack operations and interrupt operations are independent and may occur in the same cycle.

Optional Feature:
- Macro: RET_STACK_WRAP_EN.
- Defined: the stack is circular.
  - A push while full overwrites the oldest entry.
  - sp stays at DEPTH and the new value becomes the top.
  - overflow_o is still set.
  - Pops return the DEPTH most recent addresses.
- Undefined: a push while full is discarded, as described in Behaviour.

Decomposition:
- Shared package gumnut_pkg holds:
  - localparam PC_W = 12.
  - typedef logic [PC_W-1:0] pc_t.
  - RET_DEPTH_DEFAULT = 8.
  - enum int_state_e {INT_IDLE, INT_ACTIVE}.
- One natural sub-module, int_ctx_reg: the interrupt-context FSM and its saved PC/flag registers.
- ret_stack contains the entry array, the pointer logic, and an instance of int_ctx_reg.

Test Plan:
- Reset, then push 0x010, 0x020, 0x030 -> stackaddr_o = 0x030. Three pops -> 0x020, 0x010, then 0; empty_o = 1.
- Push 9 distinct values with DEPTH = 8:
  - Macro undefined -> full_o = 1, overflow_o = 1, top equals the 8th value.
  - Macro defined -> top equals the 9th value, and 8 pops return values 9 down to 2.
- Pop when empty -> underflow_o = 1 and sp stays 0. clr_err_i -> flag 0. Error event and clr_err_i in the same cycle -> flag stays 1.
- Push 0x100, then push+pop together with retaddr_i = 0x200 -> stackaddr_o = 0x200, sp unchanged at 1.
- int_save_i with PC_i = 0xABC, carry = 1, zero = 0 -> intPC_o = 0xABC, intcarry_o = 1, int_active_o = 1.
  - Second save with PC_i = 0x123 -> intPC_o stays 0xABC.
  - int_restore_i -> int_active_o = 0, intPC_o stays 0xABC.
- Assert rst_i asynchronously mid-push with sp = 3 and ACTIVE state -> all outputs are at reset values before the next clock edge.
